// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment display driver.
// Segment patterns are active-high and ordered {g,f,e,d,c,b,a}.
package seg7_pkg;

  typedef logic [6:0] seg_t;
  typedef logic [1:0] chan_t;

  localparam seg_t SEG_0     = 7'h3F;
  localparam seg_t SEG_1     = 7'h06;
  localparam seg_t SEG_2     = 7'h5B;
  localparam seg_t SEG_3     = 7'h4F;
  localparam seg_t SEG_4     = 7'h66;
  localparam seg_t SEG_5     = 7'h6D;
  localparam seg_t SEG_6     = 7'h7D;
  localparam seg_t SEG_7     = 7'h07;
  localparam seg_t SEG_8     = 7'h7F;
  localparam seg_t SEG_9     = 7'h6F;
  localparam seg_t SEG_DASH  = 7'h40;
  localparam seg_t SEG_BLANK = 7'h00;

  localparam chan_t CH_TENS  = 2'b10;
  localparam chan_t CH_UNITS = 2'b01;
  localparam chan_t AN_OFF   = 2'b00;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD to seven-segment decoder, active-high segments.
// Values 10-15 are not valid BCD and show a dash.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [6:0] o_seg
);

  // Decode one digit value to its segment pattern
  always_comb begin
    o_seg = SEG_DASH;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_DASH;
    endcase
  end

endmodule

// File: rtl/seg7_0_99.sv
// Registered two-digit (0-99) seven-segment driver. The external driver
// alternates disp_channel; this block decodes the selected digit, applies
// leading-zero blanking and output polarity, and registers seg/an.
module seg7_0_99
  import seg7_pkg::*;
#(
  parameter bit ACTIVE_LOW         = 1'b0,
  parameter bit BLANK_LEADING_ZERO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd,
  input  logic [1:0] disp_channel,
  output logic [6:0] seg,
  output logic [1:0] an
);

  logic [6:0] w_seg_dec;
  logic [6:0] w_seg_hi;
  logic [1:0] w_an_hi;
  logic [6:0] w_seg_d;
  logic [1:0] w_an_d;
  logic [6:0] r_seg;
  logic [1:0] r_an;

  bcd_to_seg7 u_dec (
    .i_bcd (bcd),
    .o_seg (w_seg_dec)
  );

  // Select digit enable and segment pattern for the requested channel
  always_comb begin
    w_seg_hi = SEG_BLANK;
    w_an_hi  = AN_OFF;
    case (disp_channel)
      CH_TENS: begin
        w_an_hi  = CH_TENS;
        // Blanked tens digit keeps its enable so the display timing is unchanged
        w_seg_hi = (BLANK_LEADING_ZERO && (bcd == 4'd0)) ? SEG_BLANK : w_seg_dec;
      end
      CH_UNITS: begin
        w_an_hi  = CH_UNITS;
        w_seg_hi = w_seg_dec;
      end
      default: begin
        w_an_hi  = AN_OFF;
        w_seg_hi = SEG_BLANK;
      end
    endcase
  end

  // Polarity is the last stage before the registers, so it costs no latency
  always_comb begin
    w_seg_d = ACTIVE_LOW ? ~w_seg_hi : w_seg_hi;
    w_an_d  = ACTIVE_LOW ? ~w_an_hi  : w_an_hi;
  end

  // Output registers; reset loads the blank state in the selected polarity
  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg <= ACTIVE_LOW ? ~SEG_BLANK : SEG_BLANK;
      r_an  <= ACTIVE_LOW ? ~AN_OFF : AN_OFF;
    end else begin
      r_seg <= w_seg_d;
      r_an  <= w_an_d;
    end
  end

  assign seg = r_seg;
  assign an  = r_an;

endmodule

// File: tb/tb_seg7_0_99.sv
// Directed self-checking bench for seg7_0_99. Three instances share the
// stimulus: default parameters, leading-zero blanking, and active-low.
module tb_seg7_0_99;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] bcd;
  logic [1:0] ch;

  logic [6:0] seg_d, seg_z, seg_l;
  logic [1:0] an_d, an_z, an_l;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  // Hand-written segment table for digits 0-9
  logic [6:0] exp_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  always #5 clk = ~clk;

  seg7_0_99 #(.ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b0)) u_dut_def (
    .clk (clk), .rst (rst), .bcd (bcd), .disp_channel (ch), .seg (seg_d), .an (an_d)
  );

  seg7_0_99 #(.ACTIVE_LOW(1'b0), .BLANK_LEADING_ZERO(1'b1)) u_dut_blz (
    .clk (clk), .rst (rst), .bcd (bcd), .disp_channel (ch), .seg (seg_z), .an (an_z)
  );

  seg7_0_99 #(.ACTIVE_LOW(1'b1), .BLANK_LEADING_ZERO(1'b0)) u_dut_low (
    .clk (clk), .rst (rst), .bcd (bcd), .disp_channel (ch), .seg (seg_l), .an (an_l)
  );

  task automatic chk(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    n_checks = n_checks + 1;
    assert (obs === exp) begin
      n_pass = n_pass + 1;
    end else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Apply inputs just after an edge, then sample 1 ns after the next edge
  task automatic step(input logic r, input logic [3:0] b, input logic [1:0] c);
    rst = r;
    bcd = b;
    ch  = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bcd = 4'd8;
    ch  = 2'b10;
    #1;

    // Reset held two cycles with digit 8 on tens
    for (int k = 0; k < 2; k++) begin
      step(1'b1, 4'd8, 2'b10);
      chk($sformatf("rst%0d_seg", k), seg_d, 7'h00);
      chk($sformatf("rst%0d_an", k), {5'b0, an_d}, 7'h00);
      chk($sformatf("rst%0d_seg_low", k), seg_l, 7'h7F);
      chk($sformatf("rst%0d_an_low", k), {5'b0, an_l}, 7'h03);
    end
    step(1'b0, 4'd8, 2'b10);
    chk("post_rst_seg", seg_d, 7'h7F);
    chk("post_rst_an", {5'b0, an_d}, 7'h02);
    chk("post_rst_seg_low", seg_l, 7'h00);
    chk("post_rst_an_low", {5'b0, an_l}, 7'h01);

    // Full decode sweep on the units channel
    for (int v = 0; v < 16; v++) begin
      step(1'b0, 4'(v), 2'b01);
      chk($sformatf("dec%0d_seg", v), seg_d, (v < 10) ? exp_tab[v] : 7'h40);
      chk($sformatf("dec%0d_an", v), {5'b0, an_d}, 7'h01);
    end

    // 0-99 alternation, tens then units
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 4'(i / 10), 2'b10);
      chk($sformatf("n%0d_tens_seg", i), seg_d, exp_tab[i / 10]);
      chk($sformatf("n%0d_tens_an", i), {5'b0, an_d}, 7'h02);
      step(1'b0, 4'(i % 10), 2'b01);
      chk($sformatf("n%0d_units_seg", i), seg_d, exp_tab[i % 10]);
      chk($sformatf("n%0d_units_an", i), {5'b0, an_d}, 7'h01);
    end

    // Spot check 47 explicitly
    step(1'b0, 4'd4, 2'b10);
    chk("n47_tens_seg_lit", seg_d, 7'h66);
    step(1'b0, 4'd7, 2'b01);
    chk("n47_units_seg_lit", seg_d, 7'h07);

    // Invalid channels
    step(1'b0, 4'd5, 2'b00);
    chk("ch00_seg", seg_d, 7'h00);
    chk("ch00_an", {5'b0, an_d}, 7'h00);
    step(1'b0, 4'd5, 2'b11);
    chk("ch11_seg", seg_d, 7'h00);
    chk("ch11_an", {5'b0, an_d}, 7'h00);

    // Leading-zero blanking: 07
    step(1'b0, 4'd0, 2'b10);
    chk("blz_tens_seg", seg_z, 7'h00);
    chk("blz_tens_an", {5'b0, an_z}, 7'h02);
    chk("noblz_tens_seg", seg_d, 7'h3F);
    step(1'b0, 4'd7, 2'b01);
    chk("blz_units_seg", seg_z, 7'h07);
    chk("blz_units_an", {5'b0, an_z}, 7'h01);
    // Nonzero tens is not blanked
    step(1'b0, 4'd3, 2'b10);
    chk("blz_tens3_seg", seg_z, 7'h4F);

    // Active-low polarity
    step(1'b0, 4'd1, 2'b01);
    chk("low_seg", seg_l, 7'h79);
    chk("low_an", {5'b0, an_l}, 7'h02);

    // Held inputs keep outputs constant
    step(1'b0, 4'd1, 2'b01);
    chk("hold_seg", seg_d, 7'h06);
    chk("hold_an", {5'b0, an_d}, 7'h01);

    // Reset mid-display has priority over a simultaneous input change
    step(1'b1, 4'd9, 2'b10);
    chk("midrst_seg", seg_d, 7'h00);
    chk("midrst_an", {5'b0, an_d}, 7'h00);
    chk("midrst_seg_low", seg_l, 7'h7F);
    chk("midrst_an_low", {5'b0, an_l}, 7'h03);
    step(1'b0, 4'd9, 2'b10);
    chk("resume_seg", seg_d, 7'h6F);
    chk("resume_an", {5'b0, an_d}, 7'h02);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
